// File: rtl/cpu_datapath_seq.sv
// cpu_datapath_seq: register bank, operand latches, ALU and flag register,
// sequenced as IDLE -> EXEC -> WB with a valid/ready operation handshake.
// Flag register order is {N, Z, F, L, C} (bit 4 down to bit 0).
module cpu_datapath_seq #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4,
  parameter int FLAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic [SEL_W-1:0]  ra_sel,
  input  logic [SEL_W-1:0]  rb_sel,
  input  logic              imm_sel,
  input  logic [7:0]        imm,
  output logic              op_done,
  output logic [DATA_W-1:0] result,
  output logic [FLAG_W-1:0] flags,
  input  logic [SEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] r_last
);

  localparam int SH_W = $clog2(DATA_W);

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_LSH = 4'd7,
    OP_RSH = 4'd8,
    OP_MOV = 4'd9,
    OP_CMP = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  logic [DATA_W-1:0] regs [NUM_REGS];
  state_e            state;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [3:0]        op_q;
  logic [SEL_W-1:0]  rd_q;
  logic [FLAG_W-1:0] flags_nxt;

  logic [DATA_W-1:0] opb_src;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic              op_writes;
  logic [DATA_W-1:0] alu_res;
  logic [FLAG_W-1:0] alu_flags;

  assign opb_src = imm_sel ? DATA_W'(imm) : regs[rb_sel];

  // Extra top bit carries the carry-out of ADD and the borrow of SUB/CMP.
  assign sum     = {1'b0, opa} + {1'b0, opb};
  assign diff    = {1'b0, opa} - {1'b0, opb};
  assign add_ovf = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1]  != opa[DATA_W-1]);
  assign sub_ovf = (opa[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != opa[DATA_W-1]);

  // ADD through MOV are the only opcodes that write rd and refresh Z/N from the result.
  assign op_writes = (op_q >= OP_ADD) && (op_q <= OP_MOV);

  assign dbg_data = regs[dbg_sel];
  assign r_last   = regs[NUM_REGS-1];

  // ALU: result and merged next-flags; unchanged fields start from the held values.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    alu_res   = result;
    alu_flags = flags;
    case (op_q)
      OP_ADD: begin
        alu_res           = sum[DATA_W-1:0];
        alu_flags[FLAG_C] = sum[DATA_W];
        alu_flags[FLAG_F] = add_ovf;
      end
      OP_SUB: begin
        alu_res           = diff[DATA_W-1:0];
        alu_flags[FLAG_C] = diff[DATA_W];
        alu_flags[FLAG_F] = sub_ovf;
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_NOT: alu_res = ~opa;
      OP_LSH: alu_res = opa << opb[SH_W-1:0];
      OP_RSH: alu_res = opa >> opb[SH_W-1:0];
      OP_MOV: alu_res = opb;
      OP_CMP: begin
        alu_res           = diff[DATA_W-1:0];
        alu_flags[FLAG_C] = diff[DATA_W];
        alu_flags[FLAG_L] = diff[DATA_W];
        alu_flags[FLAG_F] = sub_ovf;
        alu_flags[FLAG_N] = $signed(opa) < $signed(opb);
        alu_flags[FLAG_Z] = (opa == opb);
      end
      default: ;
    endcase
    if (op_writes) begin
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_N] = alu_res[DATA_W-1];
    end
  end

  // Sequencer with registered handshake outputs, operand latches, result and flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= ST_IDLE;
      op_ready  <= 1'b1;
      op_done   <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      op_q      <= OP_NOP;
      rd_q      <= '0;
      result    <= '0;
      flags     <= '0;
      flags_nxt <= '0;
    end else begin
      op_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid && op_ready) begin
            opa      <= regs[ra_sel];
            opb      <= opb_src;
            op_q     <= op_code;
            rd_q     <= rd_sel;
            op_ready <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result    <= alu_res;
          flags_nxt <= alu_flags;
          op_done   <= 1'b1;
          state     <= ST_WB;
        end
        ST_WB: begin
          flags    <= flags_nxt;
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Register bank: cleared on reset, written in WB for writing opcodes only.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the bank is architecturally visible after reset, so this memory must be cleared.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == ST_WB && op_writes) begin
      regs[rd_q] <= result;
    end
  end

endmodule

// File: tb/tb_cpu_datapath_seq.sv
// tb_cpu_datapath_seq: directed and randomized checks of cpu_datapath_seq
// against an arithmetic reference model of registers, result and flags.
module tb_cpu_datapath_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [3:0]  rd_sel;
  logic [3:0]  ra_sel;
  logic [3:0]  rb_sel;
  logic        imm_sel;
  logic [7:0]  imm;
  logic        op_done;
  logic [15:0] result;
  logic [4:0]  flags;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_data;
  logic [15:0] r_last;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state; flags are kept as {N, Z, F, L, C}.
  logic [15:0] m_regs [16];
  logic [15:0] m_result;
  logic [4:0]  m_flags;

  always #5 clk = ~clk;

  cpu_datapath_seq dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .rd_sel   (rd_sel),
    .ra_sel   (ra_sel),
    .rb_sel   (rb_sel),
    .imm_sel  (imm_sel),
    .imm      (imm),
    .op_done  (op_done),
    .result   (result),
    .flags    (flags),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .r_last   (r_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_reg(tag, 4'(i), m_regs[i]);
    end
    check({tag, "_r_last"}, r_last, m_regs[15]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_result = '0;
    m_flags  = '0;
  endtask

  // Executes one operation on the model using plain integer arithmetic.
  task automatic model_exec(input logic [3:0] op, input logic [3:0] rd,
                            input logic [15:0] a, input logic [15:0] b);
    int ua, ub, sa, sb, r, sd;
    logic n, z, f, l, c;
    bit wr;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    {n, z, f, l, c} = m_flags;
    r  = m_result;
    wr = 0;
    case (op)
      4'd1: begin
        r = ua + ub; c = (r > 65535);
        sd = sa + sb; f = (sd > 32767) || (sd < -32768); wr = 1;
      end
      4'd2: begin
        r = ua - ub; c = (ua < ub);
        sd = sa - sb; f = (sd > 32767) || (sd < -32768); wr = 1;
      end
      4'd3: begin r = ua & ub; wr = 1; end
      4'd4: begin r = ua | ub; wr = 1; end
      4'd5: begin r = ua ^ ub; wr = 1; end
      4'd6: begin r = 65535 - ua; wr = 1; end
      4'd7: begin r = ua << (ub % 16); wr = 1; end
      4'd8: begin r = ua >> (ub % 16); wr = 1; end
      4'd9: begin r = ub; wr = 1; end
      4'd10: begin
        r = ua - ub; c = (ua < ub); l = c;
        n = (sa < sb); z = (ua == ub);
        sd = sa - sb; f = (sd > 32767) || (sd < -32768);
      end
      default: ;
    endcase
    r = r & 32'h0000FFFF;
    if (wr) begin
      z = (r == 0);
      n = (r >= 32768);
      m_regs[rd] = 16'(r);
    end
    m_result = 16'(r);
    m_flags  = {n, z, f, l, c};
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                          input logic [3:0] rb, input logic isel, input logic [7:0] im);
    op_code = op;
    rd_sel  = rd;
    ra_sel  = ra;
    rb_sel  = rb;
    imm_sel = isel;
    imm     = im;
  endtask

  // One full transaction: accept, EXEC (junk inputs held valid), WB, back in IDLE.
  task automatic do_op(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic isel, input logic [7:0] im);
    logic [15:0] a, b;
    @(negedge clk);
    drive_op(op, rd, ra, rb, isel, im);
    op_valid = 1'b1;
    check("ready_idle", op_ready, 1);
    a = m_regs[ra];
    b = isel ? {8'h00, im} : m_regs[rb];
    @(negedge clk);
    drive_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom));
    check("exec_ready", op_ready, 0);
    check("exec_done", op_done, 0);
    @(negedge clk);
    model_exec(op, rd, a, b);
    check("wb_done", op_done, 1);
    check("wb_ready", op_ready, 0);
    check("wb_result", result, m_result);
    @(negedge clk);
    op_valid = 1'b0;
    check("idle_done", op_done, 0);
    check("idle_ready", op_ready, 1);
    check("flags", flags, m_flags);
    check("r_last", r_last, m_regs[15]);
    check_reg("rd_value", rd, m_regs[rd]);
  endtask

  logic [3:0]  hs_op [3];
  logic [3:0]  hs_rd [3];
  logic [3:0]  hs_ra [3];
  logic [3:0]  hs_rb [3];
  logic [7:0]  hs_im [3];
  logic        hs_is [3];

  initial begin
    int idx, phase, nphase, pulses, last_done;
    logic [3:0]  f_op, f_rd;
    logic [15:0] f_a, f_b;

    reset    = 1'b1;
    op_valid = 1'b0;
    dbg_sel  = '0;
    drive_op(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 8'd0);
    model_reset();

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ready", op_ready, 1);
    check("rst_done", op_done, 0);
    check("rst_flags", flags, 0);
    check("rst_result", result, 0);
    check_all_regs("rst_reg");

    // Immediate MOV then ADD.
    do_op(4'd9, 4'd1, 4'd0, 4'd0, 1'b1, 8'h7F);
    do_op(4'd1, 4'd2, 4'd1, 4'd0, 1'b1, 8'h01);
    check_reg("add_r2", 4'd2, 16'h0080);
    check("add_flags", flags, 5'b00000);

    // Carry/zero then signed overflow/negative.
    do_op(4'd6, 4'd3, 4'd0, 4'd0, 1'b0, 8'h00);
    do_op(4'd9, 4'd4, 4'd0, 4'd0, 1'b1, 8'h01);
    do_op(4'd1, 4'd5, 4'd3, 4'd4, 1'b0, 8'h00);
    check_reg("carry_r5", 4'd5, 16'h0000);
    check("carry_flags", flags, 5'b01001);
    do_op(4'd8, 4'd6, 4'd3, 4'd0, 1'b1, 8'h01);
    check_reg("rsh_r6", 4'd6, 16'h7FFF);
    do_op(4'd1, 4'd6, 4'd6, 4'd4, 1'b0, 8'h00);
    check_reg("ovf_r6", 4'd6, 16'h8000);
    check("ovf_flags", flags, 5'b10100);

    // CMP both operand orders; no register may change.
    do_op(4'd9, 4'd1, 4'd0, 4'd0, 1'b1, 8'h02);
    do_op(4'd6, 4'd2, 4'd4, 4'd0, 1'b0, 8'h00);
    check_reg("cmp_r2", 4'd2, 16'hFFFE);
    do_op(4'd10, 4'd1, 4'd1, 4'd2, 1'b0, 8'h00);
    check("cmp_flags", flags, 5'b00011);
    check_all_regs("cmp_regs");
    do_op(4'd10, 4'd2, 4'd2, 4'd1, 1'b0, 8'h00);
    check("cmp_swap_flags", flags, 5'b10000);
    check_all_regs("cmp_swap_regs");

    // Back-to-back handshake: op_valid held high across three distinct operations.
    hs_op[0] = 4'd1; hs_op[1] = 4'd5; hs_op[2] = 4'd7;
    for (int i = 0; i < 3; i++) begin
      hs_rd[i] = 4'($urandom_range(7, 14));
      hs_ra[i] = 4'($urandom);
      hs_rb[i] = 4'($urandom);
      hs_im[i] = 8'($urandom);
      hs_is[i] = 1'($urandom);
    end
    @(negedge clk);
    idx = 0; phase = 0; pulses = 0; last_done = -1;
    f_op = '0; f_rd = '0; f_a = '0; f_b = '0;
    drive_op(hs_op[0], hs_rd[0], hs_ra[0], hs_rb[0], hs_is[0], hs_im[0]);
    op_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      check("hs_ready", op_ready, (phase == 0));
      check("hs_done", op_done, (phase == 2));
      if (phase == 0) check("hs_flags", flags, m_flags);
      if (op_done) begin
        pulses++;
        check("hs_spacing", cyc - last_done, 3);
        last_done = cyc;
      end
      if (phase == 2) begin
        model_exec(f_op, f_rd, f_a, f_b);
        check("hs_result", result, m_result);
      end
      if (phase == 0 && op_valid) begin
        f_op = hs_op[idx];
        f_rd = hs_rd[idx];
        f_a  = m_regs[hs_ra[idx]];
        f_b  = hs_is[idx] ? {8'h00, hs_im[idx]} : m_regs[hs_rb[idx]];
        idx++;
        nphase = 1;
      end else begin
        nphase = (phase == 0) ? 0 : (phase + 1) % 3;
      end
      @(negedge clk);
      if (nphase == 1) begin
        if (idx < 3) drive_op(hs_op[idx], hs_rd[idx], hs_ra[idx], hs_rb[idx], hs_is[idx], hs_im[idx]);
        else op_valid = 1'b0;
      end
      phase = nphase;
    end
    op_valid = 1'b0;
    check("hs_pulses", pulses, 3);
    check("hs_accepted", idx, 3);
    check_all_regs("hs_regs");

    // Randomized operations, including the NOP codes 11-15.
    for (int i = 0; i < 40; i++) begin
      do_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom));
    end
    check_all_regs("rand_regs");

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    drive_op(4'd1, 4'd7, 4'd1, 4'd1, 1'b0, 8'h00);
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check("rexec_ready", op_ready, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rexec_flags", flags, 0);
    check("rexec_result", result, 0);
    for (int i = 0; i < 4; i++) begin
      check("rexec_no_done", op_done, 0);
      check("rexec_ready_idle", op_ready, 1);
      @(negedge clk);
    end
    check_reg("rexec_r7", 4'd7, 16'h0000);
    check_all_regs("rexec_regs");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_datapath_seq.md
Name: cpu_datapath_seq

Overview:
- Parametrised, sequenced successor of the 16-bit CPU datapath: register bank, two operand read paths, immediate select, internal ALU, and flag register.
- Adds a valid/ready operation handshake and a 3-state execute sequencer: accept, execute, write back.
- Writeback and flag updates are gated per opcode.
- Sits between the instruction decoder (upstream) and memory/IO (via the result and debug ports).

Parameters:
DATA_W, 16, datapath and register width (>=8, power of two)
NUM_REGS, 16, number of general registers
SEL_W, 4, register select width, clog2(NUM_REGS)
FLAG_W, 5, flag register width; fixed order {N,Z,F,L,C}

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
op_valid  in  1  decoder presents an operation
op_ready  out  1  datapath can accept; high only in IDLE
op_code  in  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 LSH, 8 RSH, 9 MOV, 10 CMP; 11-15 treated as NOP
rd_sel  in  SEL_W  destination register
ra_sel  in  SEL_W  operand A register
rb_sel  in  SEL_W  operand B register
imm_sel  in  1  1: operand B = zero-extended imm
imm  in  8  immediate
op_done  out  1  one-cycle pulse in WB
result  out  DATA_W  registered ALU result of last operation
flags  out  FLAG_W  flag register
dbg_sel  in  SEL_W  debug read select
dbg_data  out  DATA_W  combinational register read
r_last  out  DATA_W  register NUM_REGS-1, combinational

Behaviour:
- Reset: all registers, result, flags = 0; state IDLE; op_done = 0; op_ready = 1 in the first cycle after reset.
- Reset mid-operation aborts it: no register write, no flag update.
- FSM states: IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - op_ready = 1.
  - On op_valid & op_ready, latch opA = reg[ra_sel] and opB = imm_sel ? {0, imm} : reg[rb_sel].
  - Also latch op_code and rd_sel; go to EXEC.
- EXEC:
  - op_ready = 0.
  - ALU evaluates latched operands; result and next-flags registered at end of cycle; go to WB.
- WB:
  - op_done = 1.
  - reg[rd] <= result if the opcode writes; flags <= next-flags per the rules below.
  - Go to IDLE.
- Throughput: 1 op per 3 cycles.
- Accept-to-write latency: write visible on the 3rd rising edge after accept.
- Operands latched in IDLE after WB see the written value; no hazard logic needed.
- Inputs are ignored outside IDLE.
- Arithmetic: all results truncated to DATA_W.
  - ADD: A+B; C = carry-out; F = signed overflow.
  - SUB: A-B; C = borrow (A<B unsigned); F = signed overflow.
  - AND/OR/XOR: bitwise. NOT: ~A.
  - LSH: A << B[clog2(DATA_W)-1:0]. RSH: logical right shift, same amount field.
  - MOV: B.
- Writes: ADD..MOV write rd; CMP and NOP never write.
- Flag updates:
  - ADD/SUB update C, F, Z (result==0), N (result MSB); L held.
  - Logic ops, shifts, MOV update Z, N only; C, F, L held.
  - CMP computes A-B, writes nothing; sets C = L = (A<B unsigned), N = (A<B signed), Z = (A==B), F = signed overflow.
  - NOP (incl. codes 11-15): no register write, flags held, result holds previous value, op_done still pulses.
- rd = ra = rb is legal; operands were latched before the write.

Test Plan:
- Reset: assert reset 2 cycles -> op_ready = 1, flags = 0, result = 0, dbg_data = 0 for all dbg_sel, op_done = 0.
- Immediate MOV then ADD: MOV r1, imm 0x7F; ADD r2 = r1 + imm 0x01 -> op_done on cycle 3 after each accept; r2 = 0x0080, N = 0, Z = 0, C = 0, F = 0.
- Overflow/carry: r3 = 0xFFFF, r4 = 0x0001; ADD r5 = r3 + r4 -> r5 = 0x0000, C = 1, Z = 1. Then r6 = 0x7FFF, ADD r6 + r4 -> 0x8000, F = 1, N = 1.
- CMP: r1 = 0x0002, r2 = 0xFFFE; CMP r1, r2 -> no register change, L = C = 1, N = 0, Z = 0; swap operands -> L = 0, N = 1.
- Handshake: hold op_valid high continuously with 3 distinct ops -> op_ready low during EXEC/WB, exactly 3 op_done pulses spaced 3 cycles apart, no op lost or duplicated.
- Reset in EXEC: accept ADD r7 = r1 + r1, assert reset next cycle -> r7 stays 0, flags 0, no op_done pulse.
